fcel_cfg_loader: RTL and testbench
==================================

Name: fcel_cfg_loader

Overview:
- Configuration controller for an array of fcel logic cells; each cell takes a 124-bit ctrs configuration word.
- Accepts a 16-bit word stream over a valid/ready handshake and parses it into framed cell configurations.
- Verifies each frame's checksum and emits a one-cycle write strobe with cell address and 124-bit data into the external ctrs register bank.
- Sits between the bitstream source (host/ROM reader) and the fabric's per-cell ctrs registers.

Parameters:
- NCELL, 16, number of fcel cells addressable.
- ADDR_W, 4, width of cfg_addr; must satisfy 2**ADDR_W >= NCELL.
- SYNC, 4'hA, required value of header bits [15:12].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  16  configuration stream word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts s_data this cycle.
- cfg_addr  out  ADDR_W  target cell index.
- cfg_data  out  124  ctrs value for target cell.
- cfg_we  out  1  one-cycle write strobe into ctrs bank.
- busy  out  1  frame in progress (state != IDLE).
- frame_cnt  out  8  frames committed, saturates at 255.
- err_cnt  out  8  frames rejected, saturates at 255.
- err_flag  out  1  sticky error indicator.
- err_clr  in  1  clears err_flag (not err_cnt).

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Transfer: a word transfers when s_valid && s_ready on a rising clk edge.
- Frame format: 10 words.
  - Word 0, header: [15:12] = SYNC, [ADDR_W-1:0] = cell address, other bits ignored.
  - Words 1..8, payload: word k goes to assembled bits [16k-1 : 16k-16].
  - Word 9: checksum = XOR of the 8 payload words.
- States: IDLE, LOAD, CHECK, COMMIT.
- IDLE: s_ready=1.
  - Accepted word with [15:12]==SYNC: latch address, clear the payload counter, go to LOAD.
  - Accepted word with bad sync: stay in IDLE, err_cnt+1, err_flag=1.
- LOAD: s_ready=1.
  - Each accepted word is stored at the payload index and XORed into the running checksum.
  - After the 8th word, go to CHECK.
- CHECK: s_ready=1. On an accepted word:
  - Word == running checksum and address < NCELL: go to COMMIT.
  - Otherwise: err_cnt+1, err_flag=1, go to IDLE, no write.
  - An out-of-range address is only judged here, so the stream stays frame-aligned.
- COMMIT: s_ready=0 for exactly one cycle.
  - cfg_we=1, cfg_addr=latched address, cfg_data=assembled[123:0]; bits [127:124] are discarded.
  - frame_cnt+1, then return to IDLE.
- Latency: cfg_we is high in the cycle after the checksum-word handshake. Minimum frame period is 11 cycles.
- Output holding: cfg_addr and cfg_data hold their last committed values until the next COMMIT. cfg_we is 0 outside COMMIT.
- Handshake gaps: s_valid low in any state means no state change and no counter change.
- err_flag:
  - Set by any error and stays set until err_clr.
  - err_clr in the same cycle as a new error leaves err_flag=1 (set wins).
- Saturation: frame_cnt and err_cnt stop at 8'hFF.
- Reset values: s_ready=0 during the reset cycle, then 1. cfg_we=0, cfg_addr=0, cfg_data=0, busy=0, frame_cnt=0, err_cnt=0, err_flag=0, state=IDLE.
- Reset mid-frame: the partial frame is discarded and no cfg_we is issued. The next accepted word is treated as a header.
- busy is 1 in LOAD, CHECK and COMMIT.

Test Plan:
1. Reset, then frame hdr=16'hA003, payload words 16'h0001..16'h0008, chk=16'h0008 (XOR) -> required:
   - One cfg_we pulse with cfg_addr=3.
   - cfg_data[15:0]=16'h0001, cfg_data[123:112]=12'h008.
   - frame_cnt=1.
2. Same frame with chk=16'h0009 -> no cfg_we; err_cnt=1, err_flag=1. A following good frame to addr 5 then commits normally.
3. Header 16'h5003 (bad sync) followed by a valid frame -> err_cnt=1; the valid frame commits with frame_cnt=1.
4. With NCELL=12, send hdr=16'hA00E plus 8 payload words and a correct chk -> all 10 words are consumed, no cfg_we, err_cnt=1.
5. Assert rst after the 4th payload word, then send a full good frame to addr 1 -> exactly one cfg_we, with addr 1; frame_cnt=1.
6. Toggle s_valid every other cycle during a good frame -> data is assembled correctly; s_ready=0 only in COMMIT. Then pulse err_clr in the same cycle as a checksum error -> err_flag stays 1.

Source files
------------

// File: rtl/fcel_cfg_loader.sv
// fcel_cfg_loader: turns a framed 16-bit configuration stream into checked
// 124-bit ctrs writes, one frame per fcel cell.
// Frame = header (sync + cell address), 8 payload words, XOR checksum word.

// One 16-bit slice of the assembled ctrs word. It captures the stream word
// when the payload index selects this lane.
module fcel_cfg_lane #(
    parameter int VEC_W = 16,
    parameter int IDX_W = 3,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [VEC_W-1:0] din,
    output logic [VEC_W-1:0] q
);
    localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(IDX);

    // store the payload word addressed to this lane
    always_ff @(posedge clk) begin
        if (rst)                               q <= '0;
        else if (wr_en && (wr_idx == MY_IDX))  q <= din;
    end
endmodule

module fcel_cfg_loader #(
    parameter int         NCELL  = 16,
    parameter int         ADDR_W = 4,
    parameter logic [3:0] SYNC   = 4'hA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [123:0]      cfg_data,
    output logic              cfg_we,
    output logic              busy,
    output logic [7:0]        frame_cnt,
    output logic [7:0]        err_cnt,
    output logic              err_flag,
    input  logic              err_clr
);
    localparam int NUM_LANES = 8;
    localparam int VEC_W     = 16;
    localparam int IDX_W     = 3;
    localparam int CFG_W     = 124;

    // address check is done one bit wider so NCELL == 2**ADDR_W still fits
    localparam logic [ADDR_W:0]    NCELL_V  = (ADDR_W+1)'(NCELL);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_LANES-1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_COMMIT = 2'd3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [CFG_W-1:0]  data;
    } cfg_req_t;

    logic [1:0]                      state, state_nxt;
    logic [IDX_W-1:0]                pay_idx;
    logic [ADDR_W-1:0]               hdr_addr;
    logic [VEC_W-1:0]                run_chk;
    logic [NUM_LANES-1:0][VEC_W-1:0] lanes;
    logic [NUM_LANES*VEC_W-1:0]      asm_flat;
    logic                            unused_hi;
    cfg_req_t                        req;
    logic                            xfer, sync_ok, addr_ok, chk_ok;
    logic                            lane_we, err_ev, commit_ev;

    // COMMIT is the only state that stalls the source; reset also holds it off
    assign s_ready  = !rst && (state != ST_COMMIT);
    assign busy     = (state != ST_IDLE);
    assign xfer     = s_valid && s_ready;
    assign sync_ok  = (s_data[15:12] == SYNC);
    assign addr_ok  = ({1'b0, hdr_addr} < NCELL_V);
    assign chk_ok   = (s_data == run_chk) && addr_ok;
    assign lane_we  = xfer && (state == ST_LOAD);

    // lane 0 holds payload word 1, so it lands in the low bits
    assign asm_flat  = lanes;
    assign unused_hi = ^asm_flat[NUM_LANES*VEC_W-1:CFG_W];
    assign req.addr  = hdr_addr;
    assign req.data  = asm_flat[CFG_W-1:0];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        fcel_cfg_lane #(
            .VEC_W (VEC_W),
            .IDX_W (IDX_W),
            .IDX   (g)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (lane_we),
            .wr_idx (pay_idx),
            .din    (s_data),
            .q      (lanes[g])
        );
    end

    // frame sequencing; errors and commits are decided on the handshake edge
    always_comb begin
        state_nxt = state;
        err_ev    = 1'b0;
        commit_ev = 1'b0;
        case (state)
            ST_IDLE: begin
                if (xfer) begin
                    if (sync_ok) state_nxt = ST_LOAD;
                    else         err_ev    = 1'b1;
                end
            end
            ST_LOAD: begin
                if (xfer && (pay_idx == LAST_IDX)) state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                if (xfer) begin
                    if (chk_ok) begin
                        state_nxt = ST_COMMIT;
                        commit_ev = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        err_ev    = 1'b1;
                    end
                end
            end
            ST_COMMIT: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // header latch, payload index and running checksum
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_addr <= '0;
            pay_idx  <= '0;
            run_chk  <= '0;
        end else if (xfer && (state == ST_IDLE) && sync_ok) begin
            hdr_addr <= s_data[ADDR_W-1:0];
            pay_idx  <= '0;
            run_chk  <= '0;
        end else if (lane_we) begin
            pay_idx  <= pay_idx + 1'b1;
            run_chk  <= run_chk ^ s_data;
        end
    end

    // write port: loaded on the checksum handshake so it is valid during COMMIT,
    // then held until the next commit
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_we   <= 1'b0;
            cfg_addr <= '0;
            cfg_data <= '0;
        end else begin
            cfg_we <= commit_ev;
            if (commit_ev) begin
                cfg_addr <= req.addr;
                cfg_data <= req.data;
            end
        end
    end

    // saturating frame / error counters
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if ((state == ST_COMMIT) && (frame_cnt != 8'hFF)) frame_cnt <= frame_cnt + 8'd1;
            if (err_ev && (err_cnt != 8'hFF))                 err_cnt   <= err_cnt + 8'd1;
        end
    end

    // sticky error flag; a new error beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst)          err_flag <= 1'b0;
        else if (err_ev)  err_flag <= 1'b1;
        else if (err_clr) err_flag <= 1'b0;
    end
endmodule

// File: tb/tb_fcel_cfg_loader.sv
// Directed bench for fcel_cfg_loader: table of frames plus hand sequences
// for mid-frame reset, handshake gaps and err_clr/error collision.
module tb_fcel_cfg_loader;
    localparam int NCELL  = 12;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [ADDR_W-1:0] cfg_addr;
    logic [123:0]      cfg_data;
    logic              cfg_we;
    logic              busy;
    logic [7:0]        frame_cnt;
    logic [7:0]        err_cnt;
    logic              err_flag;
    logic              err_clr = 1'b0;

    always #5 clk = ~clk;

    fcel_cfg_loader #(.NCELL(NCELL), .ADDR_W(ADDR_W), .SYNC(4'hA)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_we(cfg_we), .busy(busy),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt), .err_flag(err_flag), .err_clr(err_clr)
    );

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int rdy_bad = 0;
    logic [ADDR_W-1:0] cap_addr = '0;
    logic [123:0]      cap_data = '0;

    // pulse capture and ready/strobe exclusivity monitor
    always @(negedge clk) begin
        if (cfg_we) begin
            we_cnt   = we_cnt + 1;
            cap_addr = cfg_addr;
            cap_data = cfg_data;
        end
        if (!rst && (s_ready == cfg_we)) rdy_bad = rdy_bad + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] w, input bit clr);
        int n;
        step();
        s_data  = w;
        s_valid = 1'b1;
        err_clr = clr;
        n = 0;
        while (!s_ready && n < 8) begin
            step();
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout got 0 want 1");
            s_valid = 1'b0;
            err_clr = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        err_clr = 1'b0;
        s_data  = 16'h5AFE;
    endtask

    task automatic send_frame(input logic [15:0] hdr, input logic [15:0] base,
                              input logic [15:0] chk_x, input int gap, input bit clr_last,
                              output logic [123:0] exp_data);
        logic [15:0]  c;
        logic [15:0]  w;
        logic [127:0] full;
        c    = '0;
        full = '0;
        send_word(hdr, 1'b0);
        for (int i = 0; i < 8; i++) begin
            w = base + 16'(i);
            repeat (gap) step();
            send_word(w, 1'b0);
            c = c ^ w;
            full[16*i +: 16] = w;
        end
        repeat (gap) step();
        send_word(c ^ chk_x, clr_last);
        exp_data = full[123:0];
    endtask

    task automatic do_reset();
        step();
        rst     = 1'b1;
        s_valid = 1'b0;
        err_clr = 1'b0;
        #1;
        chk("rst_ready", 128'(s_ready), 128'(0));
        step();
        chk("rst_we",    128'(cfg_we),    128'(0));
        chk("rst_addr",  128'(cfg_addr),  128'(0));
        chk("rst_data",  128'(cfg_data),  128'(0));
        chk("rst_busy",  128'(busy),      128'(0));
        chk("rst_fcnt",  128'(frame_cnt), 128'(0));
        chk("rst_ecnt",  128'(err_cnt),   128'(0));
        chk("rst_flag",  128'(err_flag),  128'(0));
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 128'(s_ready), 128'(1));
    endtask

    typedef struct {
        bit          do_rst;
        bit          lone;
        logic [15:0] hdr;
        logic [15:0] base;
        logic [15:0] chk_x;
        int          exp_we;
        logic [3:0]  exp_addr;
        logic [15:0] exp_lo;
        logic [11:0] exp_hi;
        logic [7:0]  exp_f;
        logic [7:0]  exp_e;
        bit          exp_flag;
    } vec_t;

    vec_t         tbl[9];
    logic [123:0] exp_d;
    int           w0;

    initial begin
        // good frame, bad checksum, good frame to addr 5
        tbl[0] = '{1'b1, 1'b0, 16'hA003, 16'h0001, 16'h0000, 1, 4'h3, 16'h0001, 12'h008, 8'd1, 8'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 16'hA003, 16'h0001, 16'h0001, 0, 4'h3, 16'h0000, 12'h000, 8'd1, 8'd1, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 16'hA005, 16'h0100, 16'h0000, 1, 4'h5, 16'h0100, 12'h107, 8'd2, 8'd1, 1'b1};
        // after reset: bad sync word, then a good frame
        tbl[3] = '{1'b1, 1'b1, 16'h5003, 16'h0000, 16'h0000, 0, 4'h0, 16'h0000, 12'h000, 8'd0, 8'd1, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 16'hA007, 16'hBEEF, 16'h0000, 1, 4'h7, 16'hBEEF, 12'hEF6, 8'd1, 8'd1, 1'b1};
        // addr 14 (>= NCELL) consumed and rejected; 11 is the last legal cell; 12 rejected
        tbl[5] = '{1'b0, 1'b0, 16'hA00E, 16'h0010, 16'h0000, 0, 4'h7, 16'h0000, 12'h000, 8'd1, 8'd2, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 16'hA00B, 16'hF000, 16'h0000, 1, 4'hB, 16'hF000, 12'h007, 8'd2, 8'd2, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 16'hA00C, 16'h0020, 16'h0000, 0, 4'hB, 16'h0000, 12'h000, 8'd2, 8'd3, 1'b1};
        // header bits [11:4] are ignored
        tbl[8] = '{1'b0, 1'b0, 16'hA5F2, 16'h0A0A, 16'h0000, 1, 4'h2, 16'h0A0A, 12'hA11, 8'd3, 8'd3, 1'b1};

        for (int i = 0; i < 9; i++) begin
            if (tbl[i].do_rst) do_reset();
            w0 = we_cnt;
            exp_d = '0;
            if (tbl[i].lone) send_word(tbl[i].hdr, 1'b0);
            else send_frame(tbl[i].hdr, tbl[i].base, tbl[i].chk_x, 0, 1'b0, exp_d);
            repeat (2) step();
            chk($sformatf("v%0d_we", i),   128'(we_cnt - w0), 128'(tbl[i].exp_we));
            chk($sformatf("v%0d_addr", i), 128'(cfg_addr),    128'(tbl[i].exp_addr));
            if (tbl[i].exp_we == 1) begin
                chk($sformatf("v%0d_lo", i),   128'(cap_data[15:0]),    128'(tbl[i].exp_lo));
                chk($sformatf("v%0d_hi", i),   128'(cap_data[123:112]), 128'(tbl[i].exp_hi));
                chk($sformatf("v%0d_data", i), 128'(cfg_data),          128'(exp_d));
            end
            chk($sformatf("v%0d_fcnt", i), 128'(frame_cnt), 128'(tbl[i].exp_f));
            chk($sformatf("v%0d_ecnt", i), 128'(err_cnt),   128'(tbl[i].exp_e));
            chk($sformatf("v%0d_flag", i), 128'(err_flag),  128'(tbl[i].exp_flag));
        end

        // reset after the 4th payload word drops the partial frame
        do_reset();
        w0 = we_cnt;
        send_word(16'hA009, 1'b0);
        for (int i = 0; i < 4; i++) send_word(16'h0900 + 16'(i), 1'b0);
        step();
        chk("midrst_busy", 128'(busy), 128'(1));
        do_reset();
        send_frame(16'hA001, 16'h3000, 16'h0000, 0, 1'b0, exp_d);
        repeat (2) step();
        chk("midrst_we",   128'(we_cnt - w0), 128'(1));
        chk("midrst_addr", 128'(cap_addr),    128'(1));
        chk("midrst_data", 128'(cap_data),    128'(exp_d));
        chk("midrst_fcnt", 128'(frame_cnt),   128'(1));
        chk("midrst_ecnt", 128'(err_cnt),     128'(0));

        // s_valid toggling every other cycle
        w0 = we_cnt;
        send_frame(16'hA004, 16'h7770, 16'h0000, 1, 1'b0, exp_d);
        repeat (2) step();
        chk("gap_we",   128'(we_cnt - w0), 128'(1));
        chk("gap_addr", 128'(cap_addr),    128'(4));
        chk("gap_data", 128'(cap_data),    128'(exp_d));
        chk("gap_fcnt", 128'(frame_cnt),   128'(2));
        chk("ready_only_low_in_commit", 128'(rdy_bad), 128'(0));

        // err_clr alone clears the flag but not the count
        send_word(16'h1234, 1'b0);
        step();
        chk("bad_sync_flag", 128'(err_flag), 128'(1));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        step();
        chk("clr_flag", 128'(err_flag), 128'(0));
        chk("clr_ecnt", 128'(err_cnt),  128'(1));

        // err_clr on the same edge as a checksum error: set wins
        w0 = we_cnt;
        send_frame(16'hA004, 16'h7770, 16'h0100, 0, 1'b1, exp_d);
        repeat (2) step();
        chk("collide_flag", 128'(err_flag),    128'(1));
        chk("collide_ecnt", 128'(err_cnt),     128'(2));
        chk("collide_we",   128'(we_cnt - w0), 128'(0));
        chk("collide_fcnt", 128'(frame_cnt),   128'(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
